// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neuron datapath blocks.
//   SNN_DATA_LENGTH : default width of the neuron input current word
//   syn_state_t     : frame sequencer states of synapse_accumulator
// ----------------------------------------------------------------------------
package snn_pkg;

    localparam int SNN_DATA_LENGTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } syn_state_t;

endpackage

// File: rtl/syn_weight_ram.sv
// ----------------------------------------------------------------------------
// syn_weight_ram
// Synaptic weight register file: one synchronous write port, one registered
// read port. On a same-cycle write/read to the same index the read returns
// the value held before the write.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; every entry returns to INIT
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : write value
//   rd_en    : read strobe; rd_data updates only when set
//   rd_addr  : read index
//   rd_data  : registered read data (valid the cycle after rd_en)
// ----------------------------------------------------------------------------
module syn_weight_ram #(
    parameter int          DEPTH = 8,
    parameter int          WIDTH = 28,
    parameter int unsigned INIT  = 2**24,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read and write share one edge; the read samples the array before the
    // write lands, which gives read-old-on-collision for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_W;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/synapse_accumulator.sv
// ----------------------------------------------------------------------------
// synapse_accumulator
// Samples a presynaptic spike vector, then scans the synapses one per cycle,
// summing the weights of those that spiked, and emits the sum as a one-cycle
// neuron input current.
//
// Optional feature: define SYN_SATURATE_EN to clamp the accumulator at
// all-ones instead of wrapping modulo 2**DATA_LENGTH.
//
// Handshake: a frame is accepted on a rising edge where i_frame_valid and
// o_ready are both high. o_ready is high only in IDLE; a request while busy
// is dropped (never queued) and flagged on o_overrun in that same cycle.
//
// Timing for a frame accepted at edge t:
//   edges t+1 .. t+NUM_SYN   : weight[idx] read for idx 0 .. NUM_SYN-1
//   edges t+2 .. t+NUM_SYN+1 : the read weight is added when its spike is set
//   cycle after t+NUM_SYN+1  : EMIT, o_current/o_current_valid presented
//
// Ports
//   i_clk, i_rst     : clock and synchronous active-high reset
//   i_pre_spike      : presynaptic spike vector, bit k = synapse k
//   i_frame_valid    : request to sample i_pre_spike
//   o_ready          : high in IDLE
//   i_wr_en/addr/data: weight write port, usable in any state
//   o_current        : weighted sum in EMIT, zero otherwise
//   o_current_valid  : one-cycle pulse in EMIT
//   o_overrun        : frame request seen while busy
//   o_state          : current sequencer state (observability)
// ----------------------------------------------------------------------------
module synapse_accumulator
    import snn_pkg::*;
#(
    parameter int          DATA_LENGTH  = SNN_DATA_LENGTH,
    parameter int          NUM_SYN      = 8,
    parameter int          WEIGHT_WIDTH = 28,
    parameter int unsigned INIT_WEIGHT  = 2**24,
    localparam int         AW           = $clog2(NUM_SYN)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_SYN-1:0]      i_pre_spike,
    input  logic                    i_frame_valid,
    output logic                    o_ready,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_wr_addr,
    input  logic [WEIGHT_WIDTH-1:0] i_wr_data,
    output logic [DATA_LENGTH-1:0]  o_current,
    output logic                    o_current_valid,
    output logic                    o_overrun,
    output syn_state_t              o_state
);

    // idx counts one past the last synapse so the drain cycle is visible.
    localparam logic [AW:0] IDX_END = (AW+1)'(NUM_SYN);
    localparam logic [AW:0] IDX_ONE = (AW+1)'(1);

    syn_state_t                 state_q, state_d;
    logic [NUM_SYN-1:0]         snap_q;
    logic [AW:0]                idx_q;
    logic [DATA_LENGTH-1:0]     acc_q;
    logic                       rd_vld_q;
    logic                       spk_q;
    logic [WEIGHT_WIDTH-1:0]    rd_weight;
    logic                       accept;
    logic                       scan_active;

    function automatic logic [DATA_LENGTH-1:0] acc_add(
        input logic [DATA_LENGTH-1:0] a,
        input logic [DATA_LENGTH-1:0] b
    );
        logic [DATA_LENGTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef SYN_SATURATE_EN
        // Once clamped, every later add carries out again, so it holds.
        return s[DATA_LENGTH] ? '1 : s[DATA_LENGTH-1:0];
`else
        return s[DATA_LENGTH-1:0];
`endif
    endfunction

    assign accept      = i_frame_valid && (state_q == ST_IDLE);
    assign scan_active = (state_q == ST_ACCUM) && (idx_q < IDX_END);

    syn_weight_ram #(
        .DEPTH (NUM_SYN),
        .WIDTH (WEIGHT_WIDTH),
        .INIT  (INIT_WEIGHT)
    ) u_weights (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_en   (scan_active),
        .rd_addr (idx_q[AW-1:0]),
        .rd_data (rd_weight)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. ACCUM spans NUM_SYN read cycles plus one drain
    // cycle in which the last read weight is added.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ACCUM;
            ST_ACCUM: if (idx_q == IDX_END) state_d = ST_EMIT;
            ST_EMIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: snapshot, scan index, read pipeline and accumulator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snap_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
            spk_q    <= 1'b0;
        end else if (accept) begin
            snap_q   <= i_pre_spike;
            idx_q    <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
            spk_q    <= 1'b0;
        end else begin
            // spk_q travels alongside the registered weight read.
            rd_vld_q <= scan_active;
            spk_q    <= scan_active && snap_q[idx_q[AW-1:0]];
            if (scan_active) begin
                idx_q <= idx_q + IDX_ONE;
            end
            if (rd_vld_q && spk_q) begin
                acc_q <= acc_add(acc_q, DATA_LENGTH'(rd_weight));
            end
        end
    end

    // Outputs. Gated by reset so nothing leaks out while i_rst is high.
    always_comb begin
        o_ready         = (state_q == ST_IDLE);
        o_current_valid = (state_q == ST_EMIT) && !i_rst;
        o_current       = o_current_valid ? acc_q : '0;
        o_overrun       = i_frame_valid && (state_q != ST_IDLE) && !i_rst;
        o_state         = state_q;
    end

endmodule

// File: tb/tb_synapse_accumulator.sv
// ----------------------------------------------------------------------------
// tb_synapse_accumulator
// Bench for synapse_accumulator: an 8-synapse instance for the directed and
// random frames, and a 32-synapse instance for the overflow case.
// Expected sums come from a weight array and plain arithmetic.
// ----------------------------------------------------------------------------
module tb_synapse_accumulator;
    import snn_pkg::*;

    localparam int N    = 8;
    localparam int N32  = 32;
    localparam int DL   = 32;
    localparam int WW   = 28;
    localparam int INIT = 2**24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 8-synapse instance
    logic [N-1:0]  pre_spike;
    logic          frame_valid, ready, wr_en;
    logic [2:0]    wr_addr;
    logic [WW-1:0] wr_data;
    logic [DL-1:0] current;
    logic          current_valid, overrun;
    syn_state_t    state8;

    // 32-synapse instance
    logic [N32-1:0] b_pre_spike;
    logic           b_frame_valid, b_ready, b_wr_en;
    logic [4:0]     b_wr_addr;
    logic [WW-1:0]  b_wr_data;
    logic [DL-1:0]  b_current;
    logic           b_current_valid, b_overrun;
    syn_state_t     state32;

    synapse_accumulator #(.DATA_LENGTH(DL), .NUM_SYN(N), .WEIGHT_WIDTH(WW), .INIT_WEIGHT(INIT)) dut (
        .i_clk(clk), .i_rst(rst), .i_pre_spike(pre_spike), .i_frame_valid(frame_valid),
        .o_ready(ready), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_current(current), .o_current_valid(current_valid), .o_overrun(overrun),
        .o_state(state8)
    );

    synapse_accumulator #(.DATA_LENGTH(DL), .NUM_SYN(N32), .WEIGHT_WIDTH(WW), .INIT_WEIGHT(INIT)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_pre_spike(b_pre_spike), .i_frame_valid(b_frame_valid),
        .o_ready(b_ready), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
        .o_current(b_current), .o_current_valid(b_current_valid), .o_overrun(b_overrun),
        .o_state(state32)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    longint unsigned w_model [N];
    logic [DL-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reduce an exact non-negative sum to the accumulator word.
    function automatic logic [DL-1:0] to_word(input longint unsigned total);
        longint unsigned lim;
        lim = 64'd1 << DL;
`ifdef SYN_SATURATE_EN
        return (total >= lim) ? '1 : DL'(total);
`else
        return DL'(total % lim);
`endif
    endfunction

    // Index j is read the cycle it is scanned; a write only reaches that read
    // when it is sampled strictly earlier (wr_off <= j, offsets counted in
    // edges from the accept edge).
    function automatic logic [DL-1:0] model_sum(input logic [N-1:0] spk, input int wr_off,
                                                input int wa, input longint unsigned wd);
        longint unsigned total = 0;
        for (int j = 0; j < N; j++) begin
            if (spk[j]) begin
                if (wr_off >= 0 && wa == j && j >= wr_off) total += wd;
                else total += w_model[j];
            end
        end
        return to_word(total);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) w_model[i] = INIT;
        #1;
        check("reset_ready", ready, 1'b1);
        check("reset_valid", current_valid, 1'b0);
        check("reset_current", current, 0);
        check("reset_overrun", overrun, 1'b0);
    endtask

    task automatic write_weight(input int a, input longint unsigned d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = WW'(d);
        @(negedge clk);
        wr_en = 1'b0;
        w_model[a] = d;
    endtask

    // One frame. Iteration c drives the inputs sampled at edge accept+c and
    // checks the outputs of the cycle that follows edge accept+c-1.
    // wr_off / ov_off < 0 mean no write / no extra frame request.
    task automatic run_frame(input logic [N-1:0] spk, input int wr_off, input int wa,
                             input longint unsigned wd, input int ov_off);
        logic [DL-1:0] exp;
        exp_q.push_back(model_sum(spk, wr_off, wa, wd));
        for (int c = 0; c <= N + 3; c++) begin
            @(negedge clk);
            frame_valid = (c == 0) || (c == ov_off);
            pre_spike   = (c == 0) ? spk : N'($urandom);
            wr_en       = (c == wr_off);
            wr_addr     = 3'(wa);
            wr_data     = WW'(wd);
            #1;
            if (c == 0) begin
                check("ready_pre", ready, 1'b1);
            end else begin
                check("valid", current_valid, c == N + 2);
                if (c == N + 2) begin
                    exp = exp_q.pop_front();
                    check("current", current, exp);
                end else begin
                    check("current_zero", current, 0);
                end
                check("ready", ready, c >= N + 3);
                check("overrun", overrun, c == ov_off);
            end
        end
        @(negedge clk);
        frame_valid = 1'b0;
        wr_en = 1'b0;
        if (wr_off >= 0) w_model[wa] = wd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        pre_spike = '0; frame_valid = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        b_pre_spike = '0; b_frame_valid = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;

        // Default weights: two spikes of INIT.
        reset_dut();
        run_frame(8'b0000_0101, -1, 0, 0, -1);

        // Programmed weights: 1000 + 24.
        write_weight(3, 1000);
        write_weight(7, 24);
        run_frame(8'h88, -1, 0, 0, -1);

        // Extra request three cycles after accept is dropped and flagged.
        run_frame(8'hFF, -1, 0, 0, 3);

        // Empty spike vector still emits a zero current.
        run_frame(8'h00, -1, 0, 0, -1);

        // Write collision on index 2 while it is read, then the next frame.
        reset_dut();
        for (int i = 0; i < N; i++) if (i != 2) write_weight(i, 0);
        run_frame(8'h04, 3, 2, 5, -1);
        run_frame(8'h04, -1, 0, 0, -1);

        // Random frames with writes and extra requests at random offsets.
        for (int k = 0; k < 24; k++) begin
            int wo, oo, wa;
            if ($urandom_range(0, 3) == 0)
                write_weight($urandom_range(0, N - 1), $urandom & 32'h0FFF_FFFF);
            wo = int'($urandom_range(0, N + 4)) - 1;
            oo = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, N + 2));
            wa = $urandom_range(0, N - 1);
            run_frame(N'($urandom), wo, wa, $urandom & 32'h0FFF_FFFF, oo);
        end

        // Reset in the middle of the scan: no emit, ready right after release.
        for (int i = 0; i < N; i++) write_weight(i, 7);
        @(negedge clk);
        frame_valid = 1'b1; pre_spike = 8'hFF;
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            frame_valid = 1'b0;
            rst = (c == 5) || (c == 6);
            #1;
            check("rst_valid", current_valid, 1'b0);
            check("rst_current", current, 0);
            if (c == 7) check("rst_ready", ready, 1'b1);
        end
        for (int i = 0; i < N; i++) w_model[i] = INIT;
        run_frame(8'hFF, -1, 0, 0, -1);

        // 32 synapses, all weights at maximum, all spikes.
        begin
            longint unsigned total;
            int pulses;
            logic [DL-1:0] exp32;
            for (int i = 0; i < N32; i++) begin
                @(negedge clk);
                b_wr_en = 1'b1; b_wr_addr = 5'(i); b_wr_data = '1;
            end
            @(negedge clk);
            b_wr_en = 1'b0;
            total = longint'(N32) * ((64'd1 << WW) - 1);
            exp32 = to_word(total);
            pulses = 0;
            b_frame_valid = 1'b1; b_pre_spike = '1;
            for (int c = 1; c <= N32 + 4; c++) begin
                @(negedge clk);
                b_frame_valid = 1'b0; b_pre_spike = '0;
                #1;
                if (b_current_valid) pulses++;
                check("n32_valid", b_current_valid, c == N32 + 2);
                check("n32_current", b_current, (c == N32 + 2) ? exp32 : '0);
            end
            check("n32_pulses", pulses, 1);
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
